// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer.
//   seq_state_t : FSM state encoding (6 states, 3 bits)
//   OP_MVI      : opcode that is followed by an immediate word
//   OPC_HI/LO   : position of the opcode field inside an instruction word
//   opcode_of() : extracts the opcode field from an instruction word
package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_F_INSTR = 3'd1,
    S_W_INSTR = 3'd2,
    S_W_IMM   = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } seq_state_t;

  localparam logic [2:0] OP_MVI = 3'b001;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/prog_sequencer_watchdog.sv
// seq_watchdog: 4-bit cycle counter guarding the EXEC state.
//   Clock   : system clock, rising edge
//   Resetn  : synchronous active-low reset
//   clear   : forces the count back to zero (has priority over enable)
//   enable  : advances the count by one
//   expired : count has reached TIMEOUT-1, i.e. this is the TIMEOUT-th
//             enabled cycle since the last clear
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == 4'(TIMEOUT - 1));

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instructions (and the mvi immediate) from a
// synchronous program ROM and hands them to the processor core, holding
// Run high until the core answers with Done.
//   Clock, Resetn        : clock and synchronous active-low reset
//   Start                : pulse; (re)starts at address 0 from IDLE/HALT
//   mem_addr / mem_data  : ROM address out, data back one cycle later
//   DIN, Run / Done      : processor instruction bus and handshake
//   pc                   : address of the instruction in flight
//   busy, halted, error  : status; error is sticky until reset or Start
//   instr_count          : completed instructions, saturating at 255
module prog_sequencer #(
  parameter int ADDR_W = 5,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT = 15,
  parameter logic [2:0] OP_MVI = prog_sequencer_pkg::OP_MVI
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        instr_count
);

  import prog_sequencer_pkg::*;

  // One extra bit so that PROG_LEN == 2**ADDR_W is reachable without wrap.
  localparam logic [ADDR_W:0] PROG_END = (ADDR_W + 1)'(PROG_LEN);

  seq_state_t      state;
  logic [15:0]     instr;
  logic [15:0]     imm;
  logic [ADDR_W:0] pc_plus1;
  logic [ADDR_W:0] pc_adv;
  logic            instr_mvi;
  logic            wd_expired;

  function automatic logic is_mvi(input logic [15:0] word);
    return opcode_of(word) == OP_MVI;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign instr_mvi = is_mvi(instr);
  assign pc_plus1  = {1'b0, pc} + (ADDR_W + 1)'(1);
  assign pc_adv    = {1'b0, pc} + (instr_mvi ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (state != S_EXEC),
    .enable  ((state == S_EXEC) && !Done),
    .expired (wd_expired)
  );

  // Instruction and immediate holding registers carry data only.
  always_ff @(posedge Clock) begin
    if (state == S_W_INSTR) instr <= mem_data;
    if (state == S_W_IMM)   imm   <= mem_data;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      pc          <= '0;
      mem_addr    <= '0;
      DIN         <= '0;
      Run         <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            pc          <= '0;
            mem_addr    <= '0;
            instr_count <= '0;
            error       <= 1'b0;
            state       <= S_F_INSTR;
          end
        end
        S_F_INSTR: begin
          // The ROM has already latched pc; present pc+1 now so that an
          // immediate word is on mem_data during W_IMM. Harmless when the
          // instruction turns out not to be mvi.
          mem_addr <= pc_plus1[ADDR_W-1:0];
          state    <= S_W_INSTR;
        end
        S_W_INSTR: begin
          if (is_mvi(mem_data)) begin
            state <= S_W_IMM;
          end else begin
            DIN   <= mem_data;
            Run   <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_W_IMM: begin
          if (pc_plus1 == PROG_END) begin
            // mvi in the last ROM word has no immediate to go with it.
            error <= 1'b1;
            state <= S_HALT;
          end else begin
            DIN   <= instr;
            Run   <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Done wins over both watchdog expiry and a stray Start.
          if (Done) begin
            Run         <= 1'b0;
            instr_count <= sat_inc8(instr_count);
            pc          <= pc_adv[ADDR_W-1:0];
            mem_addr    <= pc_adv[ADDR_W-1:0];
            state       <= (pc_adv >= PROG_END) ? S_HALT : S_F_INSTR;
          end else if (wd_expired) begin
            error <= 1'b1;
            Run   <= 1'b0;
            state <= S_HALT;
          end else begin
            DIN <= instr_mvi ? imm : instr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  localparam int ADDR_W   = 3;
  localparam int PROG_LEN = 8;
  localparam int TIMEOUT  = 15;
  localparam logic [2:0] MVI = 3'b001;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              Start = 1'b0;
  logic              Done = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       DIN;
  logic              Run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              error;
  logic [7:0]        instr_count;

  prog_sequencer #(
    .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .TIMEOUT(TIMEOUT), .OP_MVI(MVI)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .DIN(DIN), .Run(Run), .Done(Done),
    .pc(pc), .busy(busy), .halted(halted), .error(error),
    .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  // Program ROM: registered read, one cycle of latency.
  logic [15:0] rom [PROG_LEN];
  always @(posedge Clock) mem_data <= rom[mem_addr];

  logic rst_seen = 1'b0;
  always @(posedge Clock) rst_seen <= !Resetn;

  typedef struct {
    int          pc;
    logic [15:0] instr;
    logic [15:0] imm;
    bit          mvi;
    int          delay;
    bit          timeout;
    int          cnt_after;
    int          pc_after;
  } exp_t;

  typedef struct {
    bit err;
    int cnt;
    int pc;
  } fin_t;

  exp_t exp_q[$];
  fin_t fin_q[$];
  int   plan_q[$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] plain_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:13] == MVI) w[15:13] = 3'b110;
    return w;
  endfunction

  function automatic logic [15:0] mvi_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[15:13] = MVI;
    return w;
  endfunction

  // Reference model: walk the ROM as the processor would see it and queue
  // one record per issued instruction plus a final status record.
  task automatic build_prog(input int timeout_at, input int fixed_delay);
    int   p;
    int   n;
    int   idx;
    exp_t e;
    fin_t f;
    p = 0; n = 0; idx = 0;
    e = '{default: 0};
    f = '{default: 0};
    plan_q.delete();
    while (p < PROG_LEN) begin
      e = '{default: 0};
      e.pc = p;
      e.instr = rom[p];
      if ((rom[p] >> 13) == 1) begin
        if (p + 1 >= PROG_LEN) begin
          f.err = 1;
          break;
        end
        e.mvi = 1;
        e.imm = rom[p + 1];
      end
      if (idx == timeout_at) begin
        e.timeout = 1;
        exp_q.push_back(e);
        plan_q.push_back(0);
        f.err = 1;
        break;
      end
      e.delay = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
      n++;
      p += e.mvi ? 2 : 1;
      e.cnt_after = n;
      e.pc_after = p;
      exp_q.push_back(e);
      plan_q.push_back(e.delay);
      idx++;
    end
    f.cnt = n;
    f.pc  = f.err ? p : p % PROG_LEN;
    fin_q.push_back(f);
  endtask

  task automatic pulse_and_wait(input bit inject);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clock);
      if (halted) begin
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        return;
      end
      Start = inject && busy && ($urandom_range(0, 5) == 0);
    end
    $display("FAIL halt_wait: halted=%0d, required 1", halted);
    $fatal(1, "sequencer never halted");
  endtask

  // Processor model: answers Run with Done after the planned number of
  // cycles (0 = never), and drops stray Done pulses while Run is low.
  initial begin
    int age;
    int dly;
    age = 0;
    dly = 0;
    forever begin
      @(negedge Clock);
      Done = 1'b0;
      if (Run) begin
        age++;
        if (age == 1) dly = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
        if (age == dly) Done = 1'b1;
      end else begin
        age = 0;
        if ($urandom_range(0, 2) == 0) Done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   prev_run;
    bit   prev_busy;
    bit   prev_halt;
    int   exec_cyc;
    int   low_cnt;
    exp_t cur;
    fin_t f;
    prev_run = 0; prev_busy = 0; prev_halt = 0;
    exec_cyc = 0; low_cnt = 0;
    cur = '{default: 0};
    f = '{default: 0};
    forever begin
      @(negedge Clock);
      if (rst_seen) begin
        chk("rst_run", Run, 0);
        chk("rst_pc", pc, 0);
        chk("rst_din", DIN, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_count", instr_count, 0);
        exp_q.delete();
        fin_q.delete();
        prev_run = 0; prev_busy = 0; prev_halt = 0;
        continue;
      end
      if (Run && !prev_run) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL issue_unexpected: Run rose with DIN=%0h pc=%0d, required no issue", DIN, pc);
          cur = '{default: 0};
        end else begin
          cur = exp_q.pop_front();
          chk("issue_din", DIN, cur.instr);
          chk("issue_pc", pc, cur.pc);
          chk("issue_latency", low_cnt, cur.mvi ? 3 : 2);
        end
        exec_cyc = 1;
      end else if (Run) begin
        exec_cyc++;
        chk("exec_din", DIN, cur.mvi ? cur.imm : cur.instr);
      end else if (prev_run) begin
        if (cur.timeout) begin
          chk("wd_cycles", exec_cyc, TIMEOUT);
          chk("wd_error", error, 1);
          chk("wd_halted", halted, 1);
          chk("wd_pc", pc, cur.pc);
        end else begin
          chk("exec_cycles", exec_cyc, cur.delay);
          chk("count_after", instr_count, cur.cnt_after);
          chk("pc_after", pc, cur.pc_after % PROG_LEN);
          chk("mem_addr_after", mem_addr, cur.pc_after % PROG_LEN);
          chk("halt_after", halted, (cur.pc_after >= PROG_LEN) ? 1 : 0);
        end
      end
      if (!Run) begin
        if (prev_run || (busy && !prev_busy)) low_cnt = 1;
        else low_cnt++;
      end
      if (busy && !prev_busy) begin
        chk("start_count", instr_count, 0);
        chk("start_error", error, 0);
        chk("start_pc", pc, 0);
        chk("start_mem_addr", mem_addr, 0);
      end
      if (halted && !prev_halt) begin
        if (fin_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL halt_unexpected: halted with count=%0d, required no halt", instr_count);
          f = '{default: 0};
        end else begin
          f = fin_q.pop_front();
          chk("fin_error", error, f.err);
          chk("fin_count", instr_count, f.cnt);
          chk("fin_pc", pc, f.pc);
          chk("fin_busy", busy, 0);
          chk("fin_run", Run, 0);
          chk("fin_leftover", exp_q.size(), 0);
        end
      end else if (halted) begin
        chk("halt_hold_count", instr_count, f.cnt);
        chk("halt_hold_run", Run, 0);
      end
      prev_run  = Run;
      prev_busy = busy;
      prev_halt = halted;
    end
  end

  initial begin
    for (int i = 0; i < PROG_LEN; i++) rom[i] = 16'h0000;
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Single-word instruction, Done two cycles after Run.
    rom[0] = 16'h0040;
    for (int i = 1; i < PROG_LEN; i++) rom[i] = plain_word();
    build_prog(-1, 2);
    pulse_and_wait(0);

    // mvi followed by its immediate.
    rom[0] = 16'h2000;
    rom[1] = 16'h00AB;
    for (int i = 2; i < PROG_LEN; i++) rom[i] = plain_word();
    build_prog(-1, 3);
    pulse_and_wait(0);

    // Watchdog on the first instruction, then a clean restart.
    for (int i = 0; i < PROG_LEN; i++) rom[i] = plain_word();
    build_prog(0, 0);
    pulse_and_wait(0);
    build_prog(-1, 0);
    pulse_and_wait(1);

    // mvi in the last ROM word.
    for (int i = 0; i < PROG_LEN - 1; i++) rom[i] = plain_word();
    rom[PROG_LEN - 1] = 16'h2123;
    build_prog(-1, 1);
    pulse_and_wait(0);

    // Reset while executing the instruction at pc=3.
    for (int i = 0; i < PROG_LEN; i++) rom[i] = 16'h0040 + 16'(i);
    build_prog(-1, 4);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (Run && pc == 3) break;
    end
    if (!(Run && pc == 3)) begin
      $display("FAIL reset_wait: Run=%0d pc=%0d, required Run=1 pc=3", Run, pc);
      $fatal(1, "pc=3 never reached");
    end
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    plan_q.delete();
    repeat (2) @(negedge Clock);

    // Randomised programs with occasional watchdog expiry.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < PROG_LEN; i++)
        rom[i] = ($urandom_range(0, 2) == 0) ? mvi_word() : plain_word();
      build_prog(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1, 0);
      pulse_and_wait(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Instruction-stream controller for the 16-bit processor core. It walks a program counter through a synchronous program ROM and fetches each instruction word, plus the immediate word for mvi. It presents the words on the core's DIN, drives Run, and waits for Done before advancing. It sits between program memory and the processor and is the only driver of DIN and Run.

Parameters:
ADDR_W, 5, width of program counter / ROM address
PROG_LEN, 32, number of ROM words; the sequencer halts when pc reaches PROG_LEN
TIMEOUT, 15, max cycles in EXEC without Done before error halt (fits 4-bit watchdog)
OP_MVI, 3'b001, opcode in DIN[15:13] that takes a second (immediate) word

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  synchronous, active-low reset
Start  input  1  one-cycle pulse; begins execution from address 0 when IDLE or HALT
mem_addr  output  ADDR_W  ROM read address; data returns on mem_data one cycle later
mem_data  input  16  ROM read data
DIN  output  16  word presented to processor DIN
Run  output  1  processor Run
Done  input  1  processor Done (level, sampled on Clock)
pc  output  ADDR_W  address of the instruction currently fetched/executing
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
error  output  1  sticky; set on watchdog expiry; cleared by reset or Start
instr_count  output  8  instructions completed since Start; saturates at 255

Behaviour:
- Reset (Resetn=0 at an edge): state=IDLE; pc=0, mem_addr=0, DIN=0, Run=0, busy=0, halted=0, error=0, instr_count=0, watchdog=0. Reset overrides every other input and applies mid-operation.
- States: IDLE, F_INSTR, W_INSTR, W_IMM, EXEC, HALT.
- IDLE/HALT + Start: pc=0, instr_count=0, error=0, mem_addr=0 -> F_INSTR.
- F_INSTR: ROM read of pc in flight -> W_INSTR.
- W_INSTR: capture mem_data as instr.
  - If instr[15:13]==OP_MVI: set mem_addr=pc+1 -> W_IMM.
  - Otherwise -> EXEC.
- W_IMM: capture mem_data as imm -> EXEC.
  - If pc+1 == PROG_LEN, the immediate is missing: error=1, no EXEC -> HALT.
- EXEC:
  - Run=1 for the whole state.
  - First EXEC cycle: DIN=instr.
  - Later cycles: DIN=imm for mvi, otherwise DIN=instr.
  - Watchdog counts EXEC cycles.
  - On Done=1: Run=0 next cycle; instr_count+=1 (saturating); pc += 2 for mvi, +1 otherwise; mem_addr follows pc.
  - After Done: if new pc >= PROG_LEN -> HALT, else -> F_INSTR.
  - Watchdog reaches TIMEOUT with no Done: error=1, Run=0 -> HALT; pc is not advanced.
- Latency: non-mvi instruction issue = 2 cycles after F_INSTR entry; mvi issue = 3 cycles.
- Run/DIN change only on Clock edges; Run is never high outside EXEC.
- Done outside EXEC is ignored.
- Start outside IDLE/HALT is ignored.
- Start and Done in the same cycle while in EXEC: Done is processed and Start is ignored.
- pc arithmetic is done at ADDR_W+1 bits so that PROG_LEN = 2^ADDR_W is detected without wrap.
- busy = (state != IDLE && state != HALT); halted = (state == HALT).

Decomposition:
- Shared package holds: state encoding typedef (6 states, 3-bit), the OP_MVI constant, and the opcode field position [15:13].
- One natural sub-module, seq_watchdog: 4-bit counter with clear/enable and an expired flag.
- The remainder is a single FSM with its datapath registers (instr, imm, pc, counters).

Test Plan:
- Reset mid-EXEC (Run=1, pc=3): assert Resetn=0 for one edge -> Run=0, pc=0, DIN=0, state IDLE, instr_count=0.
- ROM[0]=mv 16'h0040, ROM[1..]: Start, Done pulse 2 cycles after Run rises -> DIN=16'h0040 while Run, instr_count=1, pc=1, F_INSTR next.
- ROM[0]=mvi 16'h2000, ROM[1]=16'h00AB: Start -> first EXEC cycle DIN=16'h2000, then DIN=16'h00AB until Done; pc advances to 2.
- PROG_LEN=4, four single-word instructions each acknowledged -> halted=1 after the 4th Done, instr_count=4, busy=0; a Done pulse in HALT leaves counts unchanged.
- Done never asserted -> error=1 and HALT exactly TIMEOUT=15 cycles after Run rose; pc unchanged. Then Start -> error cleared, restart at pc=0.
- mvi at ROM[PROG_LEN-1] -> error=1, HALT, Run never asserted for that word.
